// File: rtl/audio_if_pkg.sv
// audio_if_pkg: shared sample and state types for the codec
// audio interface blocks.
package audio_if_pkg;

  localparam int DEF_WIDTH     = 24;
  localparam int DEF_SLOT_BITS = 32;

  typedef logic signed [23:0] sample_t;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    LEFT,
    RIGHT
  } tx_state_t;

endpackage

// File: rtl/audio_dac_tx_edge_sync.sv
// edge_sync: 2-FF synchroniser for an asynchronous codec clock
// with one-clk rise/fall pulses derived from the synced level.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[1:0], d};
  end

  assign q    = sr[1];
  assign rise =  sr[1] & ~sr[2];
  assign fall = ~sr[1] &  sr[2];

endmodule

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: I2S serialiser slaved to codec bclk/lrclk.
// Build option DAC_TX_HOLD_LAST_EN repeats the last pair on underrun.
module audio_dac_tx
  import audio_if_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int MIN_SLOT  = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bclk,
  input  logic                    lrclk,
  input  logic signed [WIDTH-1:0] left_in,
  input  logic signed [WIDTH-1:0] right_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    dacdat,
  output logic                    next_lrclk_fall,
  output logic                    underrun,
  output logic                    frame_err
);

  localparam int CW = $clog2(SLOT_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SLOT_BITS);
  localparam logic [CW-1:0] SHORT_LIM = CW'(MIN_SLOT - 1);

  logic b_q_unused, b_rise_unused, bfall;
  logic lr_s, l_rise_unused, lfall;

  edge_sync u_bclk (
    .clk  (clk),
    .rst  (rst),
    .d    (bclk),
    .q    (b_q_unused),
    .rise (b_rise_unused),
    .fall (bfall)
  );

  edge_sync u_lrclk (
    .clk  (clk),
    .rst  (rst),
    .d    (lrclk),
    .q    (lr_s),
    .rise (l_rise_unused),
    .fall (lfall)
  );

  tx_state_t state, state_nx;

  logic             lr_last, primed, hold_full;
  logic [WIDTH-1:0] hold_l, hold_r;
  logic [WIDTH-1:0] sh_l, sh_r, shift;
  logic [CW-1:0]    bit_cnt;
  logic             go, bound, rb, accept;

  assign sample_ready = ~hold_full;
  assign accept = sample_valid & ~hold_full;
  // the lfall that leaves WAIT_SYNC coincides with the first boundary
  assign go    = bfall & ((state != WAIT_SYNC) | lfall);
  assign bound = go & (lr_s != lr_last);
  assign rb    = bound & lr_s;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SYNC;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_SYNC: if (lfall)          state_nx = LEFT;
      LEFT:      if (bfall && lr_s)  state_nx = RIGHT;
      RIGHT:     if (bfall && !lr_s) state_nx = LEFT;
      default:                       state_nx = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l          <= '0;
      hold_r          <= '0;
      hold_full       <= 1'b0;
      sh_l            <= '0;
      sh_r            <= '0;
      shift           <= '0;
      bit_cnt         <= '0;
      lr_last         <= 1'b0;
      primed          <= 1'b0;
      dacdat          <= 1'b0;
      next_lrclk_fall <= 1'b0;
      underrun        <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      next_lrclk_fall <= lfall;
      if (bfall) lr_last <= lr_s;
      if (accept) begin
        hold_l    <= left_in;
        hold_r    <= right_in;
        hold_full <= 1'b1;
      end
      if (bound) begin
        dacdat  <= 1'b0;
        bit_cnt <= '0;
        primed  <= 1'b1;
        // first boundary after sync has no full slot behind it
        if (primed && bit_cnt < SHORT_LIM) frame_err <= 1'b1;
        if (rb) begin
          shift <= sh_r;
        end else if (hold_full) begin
          sh_l      <= hold_l;
          sh_r      <= hold_r;
          shift     <= hold_l;
          hold_full <= 1'b0;
        end else begin
          underrun <= 1'b1;
`ifdef DAC_TX_HOLD_LAST_EN
          shift <= sh_l;
`else
          sh_l  <= '0;
          sh_r  <= '0;
          shift <= '0;
`endif
        end
      end else if (go) begin
        dacdat <= shift[WIDTH-1];
        shift  <= {shift[WIDTH-2:0], 1'b0};
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == CNT_MAX - 1'b1) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: directed bench for audio_dac_tx, acting as the
// codec clock master and capturing dacdat on bclk rising edges.
module tb_audio_dac_tx;
  import audio_if_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    bclk = 1'b1;
  logic    lrclk = 1'b1;
  sample_t left_in = '0;
  sample_t right_in = '0;
  logic    sample_valid = 1'b0;
  logic    sample_ready, dacdat, next_lrclk_fall;
  logic    underrun, frame_err;

  int checks = 0;
  int errors = 0;
  int nlf_cnt = 0;
  logic [31:0] cap_l, cap_r;
  logic        rdy_mid;

  audio_dac_tx #(
    .WIDTH(24),
    .SLOT_BITS(32),
    .MIN_SLOT(25)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bclk(bclk),
    .lrclk(lrclk),
    .left_in(left_in),
    .right_in(right_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .dacdat(dacdat),
    .next_lrclk_fall(next_lrclk_fall),
    .underrun(underrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (next_lrclk_fall) nlf_cnt++;

  function automatic logic [31:0] exp_slot(input sample_t w,
                                           input int slot);
    logic [31:0] full;
    full = {1'b0, w, 7'b0};
    return full >> (32 - slot);
  endfunction

  // one frame: bclk period 80 ns (8 clk), lrclk moves on bclk fall
  task automatic send_frame(input int slot, input int rst_at);
    cap_l = '0;
    cap_r = '0;
    rdy_mid = 1'b0;
    @(posedge clk);
    #2;
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < slot; k++) begin
        bclk = 1'b0;
        if (k == 0) lrclk = (ch == 1);
        #40;
        bclk = 1'b1;
        if (ch == 0) cap_l = {cap_l[30:0], dacdat};
        else         cap_r = {cap_r[30:0], dacdat};
        if (ch == 0 && k == 1) rdy_mid = sample_ready;
        if (ch == 0 && k == rst_at) begin
          #5 rst = 1'b1;
          #20 rst = 1'b0;
          #15;
        end else begin
          #40;
        end
      end
    end
  endtask

  task automatic offer(input sample_t l, input sample_t r,
                       output logic took);
    @(negedge clk);
    left_in = l;
    right_in = r;
    sample_valid = 1'b1;
    took = sample_ready;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2 bclk = ~bclk;
    end
    @(negedge clk);
    checks++;
    if (dacdat !== 1'b0)
      $display("FAIL rst_dacdat: got %b want 0", dacdat);
    if (dacdat !== 1'b0) errors++;
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", sample_ready);
    end
    checks++;
    if (underrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: got %b%b want 00",
               underrun, frame_err);
    end
    rst = 1'b0;
    repeat (5) begin
      repeat (4) @(posedge clk);
      #2 bclk = ~bclk;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (nlf_cnt !== 0) begin
      errors++;
      $display("FAIL rst_no_strobe: got %0d want 0", nlf_cnt);
    end
    checks++;
    if (dacdat !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle_dacdat: got %b want 0", dacdat);
    end
  endtask

  task automatic test_basic;
    logic took;
    int   n0;
    offer(24'h800001, 24'h7FFFFF, took);
    checks++;
    if (took !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept: got %b want 1", took);
    end
    @(negedge clk);
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_low: got %b want 0", sample_ready);
    end
    n0 = nlf_cnt;
    send_frame(32, -1);
    checks++;
    if (cap_l !== exp_slot(24'h800001, 32)) begin
      errors++;
      $display("FAIL basic_left: got %h want %h",
               cap_l, exp_slot(24'h800001, 32));
    end
    checks++;
    if (cap_r !== exp_slot(24'h7FFFFF, 32)) begin
      errors++;
      $display("FAIL basic_right: got %h want %h",
               cap_r, exp_slot(24'h7FFFFF, 32));
    end
    checks++;
    if (rdy_mid !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_back: got %b want 1", rdy_mid);
    end
    checks++;
    if (nlf_cnt !== n0 + 1) begin
      errors++;
      $display("FAIL basic_strobe: got %0d want %0d",
               nlf_cnt, n0 + 1);
    end
    checks++;
    if (underrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got %b%b want 00",
               underrun, frame_err);
    end
  endtask

  task automatic test_back_to_back;
    logic took;
    offer(24'h123456, 24'hABCDEF, took);
    checks++;
    if (took !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_accept: got %b want 1", took);
    end
    offer(24'h654321, 24'h0F0F0F, took);
    checks++;
    if (took !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_ready: got %b want 0", took);
    end
    send_frame(32, -1);
    checks++;
    if (cap_l !== exp_slot(24'h123456, 32) ||
        cap_r !== exp_slot(24'hABCDEF, 32)) begin
      errors++;
      $display("FAIL bp_first_frame: got %h/%h want %h/%h",
               cap_l, cap_r, exp_slot(24'h123456, 32),
               exp_slot(24'hABCDEF, 32));
    end
    offer(24'h654321, 24'h0F0F0F, took);
    checks++;
    if (took !== 1'b1) begin
      errors++;
      $display("FAIL bp_reaccept: got %b want 1", took);
    end
    send_frame(32, -1);
    checks++;
    if (cap_l !== exp_slot(24'h654321, 32) ||
        cap_r !== exp_slot(24'h0F0F0F, 32)) begin
      errors++;
      $display("FAIL bp_second_frame: got %h/%h want %h/%h",
               cap_l, cap_r, exp_slot(24'h654321, 32),
               exp_slot(24'h0F0F0F, 32));
    end
  endtask

  task automatic test_underrun;
    logic        took;
    logic [31:0] el, er;
    offer(24'h000001, 24'h000003, took);
    send_frame(32, -1);
    checks++;
    if (cap_l !== exp_slot(24'h000001, 32) || underrun !== 1'b0)
    begin
      errors++;
      $display("FAIL ur_fed_frame: got %h ur=%b want %h ur=0",
               cap_l, underrun, exp_slot(24'h000001, 32));
    end
    send_frame(32, -1);
`ifdef DAC_TX_HOLD_LAST_EN
    el = exp_slot(24'h000001, 32);
    er = exp_slot(24'h000003, 32);
`else
    el = '0;
    er = '0;
`endif
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL ur_flag: got %b want 1", underrun);
    end
    checks++;
    if (cap_l !== el) begin
      errors++;
      $display("FAIL ur_left: got %h want %h", cap_l, el);
    end
    checks++;
    if (cap_r !== er) begin
      errors++;
      $display("FAIL ur_right: got %h want %h", cap_r, er);
    end
  endtask

  task automatic test_short_slot;
    logic took;
    int   n0;
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL short_pre_err: got %b want 0", frame_err);
    end
    offer(24'hC3A5F0, 24'h5A5A5A, took);
    n0 = nlf_cnt;
    send_frame(16, -1);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL short_err: got %b want 1", frame_err);
    end
    checks++;
    if (cap_l !== exp_slot(24'hC3A5F0, 16) ||
        cap_r !== exp_slot(24'h5A5A5A, 16)) begin
      errors++;
      $display("FAIL short_trunc: got %h/%h want %h/%h",
               cap_l, cap_r, exp_slot(24'hC3A5F0, 16),
               exp_slot(24'h5A5A5A, 16));
    end
    checks++;
    if (nlf_cnt !== n0 + 1) begin
      errors++;
      $display("FAIL short_strobe: got %0d want %0d",
               nlf_cnt, n0 + 1);
    end
  endtask

  task automatic test_mid_reset;
    logic        took;
    logic [31:0] el;
    offer(24'h2468AC, 24'h13579B, took);
    send_frame(32, 10);
    el = exp_slot(24'h2468AC, 32) & 32'hFFE0_0000;
    checks++;
    if (cap_l !== el || cap_r !== 32'h0) begin
      errors++;
      $display("FAIL mrst_abort: got %h/%h want %h/00000000",
               cap_l, cap_r, el);
    end
    checks++;
    if (underrun !== 1'b0 || frame_err !== 1'b0 ||
        sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL mrst_state: got ur=%b fe=%b rdy=%b want 0 0 1",
               underrun, frame_err, sample_ready);
    end
    offer(24'hFEDCBA, 24'h0A0B0C, took);
    send_frame(32, -1);
    checks++;
    if (cap_l !== exp_slot(24'hFEDCBA, 32) ||
        cap_r !== exp_slot(24'h0A0B0C, 32)) begin
      errors++;
      $display("FAIL mrst_clean: got %h/%h want %h/%h",
               cap_l, cap_r, exp_slot(24'hFEDCBA, 32),
               exp_slot(24'h0A0B0C, 32));
    end
    checks++;
    if (underrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL mrst_flags: got %b%b want 00",
               underrun, frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_short_slot();
    test_mid_reset();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
